// File: rtl/pri_islip_scheduler.sv
// Multi-iteration priority-aware iSLIP scheduler for an N x N crossbar.
// Grant/accept iterations with round-robin tie-break pointers.
module pri_islip_scheduler #(
    parameter  int N    = 4,
    parameter  int P    = 16,
    parameter  int ITER = 4,
    localparam int PW   = $clog2(P),
    localparam int CW   = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N*N*PW-1:0] pri_req_in,
    output logic [N*N-1:0]    decision,
    output logic              decision_ready,
    output logic              busy,
    output logic [CW-1:0]     match_count
);

    localparam int PTRW = $clog2(N);
    localparam int IW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, GRANT, ACCEPT, DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    req_q [N][N];
    logic [N*N-1:0]   match_q;
    logic [N*N-1:0]   match_nx;
    logic [N*N-1:0]   acc_m;
    logic [N-1:0]     in_m, out_m;
    logic [PTRW-1:0]  g_ptr [N];
    logic [PTRW-1:0]  a_ptr [N];
    logic [N-1:0]     gnt_v_q, gnt_v_d;
    logic [PTRW-1:0]  gnt_i_q [N];
    logic [PTRW-1:0]  gnt_i_d [N];
    logic [IW-1:0]    iter_q;
    logic [CW-1:0]    nx_cnt;

    function automatic int wrap_idx(input int x);
        return (x >= N) ? x - N : x;
    endfunction

    function automatic logic [PTRW-1:0] ptr_inc(input int x);
        return (x == N - 1) ? '0 : PTRW'(x + 1);
    endfunction

    // Rows/columns already used by the match set of this round
    always_comb begin
        in_m  = '0;
        out_m = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (match_q[i*N+j]) begin
                    in_m[i]  = 1'b1;
                    out_m[j] = 1'b1;
                end
            end
        end
    end

    // Grant: each free output picks the highest-priority free requester, RR from g_ptr
    always_comb begin
        logic [PW-1:0] best;
        int            idx;
        best    = '0;
        idx     = 0;
        gnt_v_d = '0;
        for (int j = 0; j < N; j++) begin
            gnt_i_d[j] = '0;
            best       = '0;
            for (int k = 0; k < N; k++) begin
                idx = wrap_idx(int'(g_ptr[j]) + k);
                if (!out_m[j] && !in_m[idx] && req_q[idx][j] > best) begin
                    best       = req_q[idx][j];
                    gnt_v_d[j] = 1'b1;
                    gnt_i_d[j] = PTRW'(idx);
                end
            end
        end
    end

    // Accept: each free input picks its best grant, RR from a_ptr
    always_comb begin
        logic [PW-1:0] best;
        int            idx;
        int            sel;
        best  = '0;
        idx   = 0;
        sel   = -1;
        acc_m = '0;
        for (int i = 0; i < N; i++) begin
            best = '0;
            sel  = -1;
            for (int k = 0; k < N; k++) begin
                idx = wrap_idx(int'(a_ptr[i]) + k);
                if (!in_m[i] && gnt_v_q[idx] && int'(gnt_i_q[idx]) == i
                    && req_q[i][idx] > best) begin
                    best = req_q[i][idx];
                    sel  = idx;
                end
            end
            if (sel >= 0) acc_m[i*N+sel] = 1'b1;
        end
    end

    // Match set after this iteration and its population count
    always_comb begin
        match_nx = match_q | acc_m;
        nx_cnt   = '0;
        for (int b = 0; b < N * N; b++) nx_cnt = nx_cnt + CW'(match_nx[b]);
    end

    // Round sequencing; stop early once an iteration adds nothing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = GRANT;
            GRANT:   state_d = ACCEPT;
            ACCEPT:  state_d = (acc_m == '0 || iter_q == IW'(ITER - 1)) ? DONE : GRANT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, match set, pointers and published result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            match_q     <= '0;
            gnt_v_q     <= '0;
            iter_q      <= '0;
            decision    <= '0;
            match_count <= '0;
            for (int i = 0; i < N; i++) begin
                g_ptr[i]   <= '0;
                a_ptr[i]   <= '0;
                gnt_i_q[i] <= '0;
                for (int j = 0; j < N; j++) req_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        match_q <= '0;
                        iter_q  <= '0;
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                req_q[i][j] <= pri_req_in[(i*N+j)*PW +: PW];
                    end
                end
                GRANT: begin
                    gnt_v_q <= gnt_v_d;
                    for (int j = 0; j < N; j++) gnt_i_q[j] <= gnt_i_d[j];
                end
                ACCEPT: begin
                    match_q <= match_nx;
                    iter_q  <= iter_q + 1'b1;
                    if (iter_q == '0) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                if (acc_m[i*N+j]) begin
                                    a_ptr[i] <= ptr_inc(j);
                                    g_ptr[j] <= ptr_inc(i);
                                end
                            end
                        end
                    end
                    if (state_d == DONE) begin
                        decision    <= match_nx;
                        match_count <= nx_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign decision_ready = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_pri_islip_scheduler.sv
// Randomized bench for pri_islip_scheduler against a priority/RR-distance
// reference model of the iSLIP rules.
module tb_pri_islip_scheduler;

    localparam int N    = 4;
    localparam int P    = 16;
    localparam int ITER = 4;
    localparam int PW   = 4;
    localparam int CW   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [N*N*PW-1:0] pri_req_in = '0;
    logic [N*N-1:0]    decision;
    logic              decision_ready;
    logic              busy;
    logic [CW-1:0]     match_count;

    int total = 0;
    int bad   = 0;

    int m_req [N][N];
    int m_g [N];
    int m_a [N];

    pri_islip_scheduler #(.N(N), .P(P), .ITER(ITER)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pri_req_in(pri_req_in),
        .decision(decision),
        .decision_ready(decision_ready),
        .busy(busy),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*N*PW-1:0] pack_req();
        logic [N*N*PW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                v[(i*N+j)*PW +: PW] = PW'(m_req[i][j]);
        return v;
    endfunction

    // Rank candidates by (priority desc, RR distance asc) as a single key
    task automatic model_round(output int mask, output int cnt, output int k);
        int in_to [N];
        int out_to [N];
        int gnt [N];
        int key, best;
        bit any;
        for (int x = 0; x < N; x++) begin
            in_to[x]  = -1;
            out_to[x] = -1;
        end
        k = 0;
        do begin
            k++;
            any = 0;
            for (int j = 0; j < N; j++) begin
                gnt[j] = -1;
                best   = 1 << 30;
                if (out_to[j] < 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (in_to[i] < 0 && m_req[i][j] > 0) begin
                            key = (P - m_req[i][j]) * N + ((i - m_g[j] + N) % N);
                            if (key < best) begin
                                best   = key;
                                gnt[j] = i;
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                int pick;
                pick = -1;
                best = 1 << 30;
                if (in_to[i] < 0) begin
                    for (int j = 0; j < N; j++) begin
                        if (gnt[j] == i) begin
                            key = (P - m_req[i][j]) * N + ((j - m_a[i] + N) % N);
                            if (key < best) begin
                                best = key;
                                pick = j;
                            end
                        end
                    end
                end
                if (pick >= 0) begin
                    in_to[i]     = pick;
                    out_to[pick] = i;
                    any          = 1;
                    if (k == 1) begin
                        m_g[pick] = (i + 1) % N;
                        m_a[i]    = (pick + 1) % N;
                    end
                end
            end
        end while (any && k < ITER);
        mask = 0;
        cnt  = 0;
        for (int i = 0; i < N; i++)
            if (in_to[i] >= 0) begin
                mask |= 1 << (i * N + in_to[i]);
                cnt++;
            end
    endtask

    task automatic run_round(input string tag, input bit poke,
                             input int fix_mask, input int fix_lat);
        int mask, cnt, k, edges;
        bit ok;
        int rc, cc;
        logic [N*N-1:0] held;
        model_round(mask, cnt, k);
        @(negedge clk);
        pri_req_in = pack_req();
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        chk({tag, ".busy_on"}, 32'(busy), 1);
        while (!decision_ready && edges < 40) begin
            if (poke && edges == 2) begin
                start      = 1'b1;
                pri_req_in = {$urandom, $urandom};
            end
            @(negedge clk);
            start = 1'b0;
            edges++;
        end
        chk({tag, ".lat"}, edges, 2 * k + 1);
        chk({tag, ".dec"}, 32'(decision), mask);
        chk({tag, ".cnt"}, 32'(match_count), cnt);
        chk({tag, ".busy_done"}, 32'(busy), 1);
        if (fix_mask >= 0) begin
            chk({tag, ".fix_dec"}, 32'(decision), fix_mask);
            chk({tag, ".fix_lat"}, edges, fix_lat);
        end
        ok = 1;
        for (int i = 0; i < N; i++) begin
            rc = 0;
            cc = 0;
            for (int j = 0; j < N; j++) begin
                rc += int'(decision[i*N+j]);
                cc += int'(decision[j*N+i]);
                if (decision[i*N+j] && m_req[i][j] == 0) ok = 0;
            end
            if (rc > 1 || cc > 1) ok = 0;
        end
        chk({tag, ".perm"}, 32'(ok), 1);
        held = decision;
        @(negedge clk);
        chk({tag, ".ready_pulse"}, 32'(decision_ready), 0);
        chk({tag, ".busy_off"}, 32'(busy), 0);
        chk({tag, ".hold"}, 32'(decision), 32'(held));
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m_req[i][j] = v;
    endtask

    initial begin
        int sawr;
        for (int x = 0; x < N; x++) begin
            m_g[x] = 0;
            m_a[x] = 0;
        end
        #12;
        chk("rst.dec", 32'(decision), 0);
        chk("rst.cnt", 32'(match_count), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ready", 32'(decision_ready), 0);
        @(negedge clk);
        reset = 1'b0;

        set_all(15);
        run_round("t1", 0, 32'h8421, 9);
        run_round("t2", 0, 32'h8412, 9);

        set_all(0);
        m_req[0][1] = 3;
        m_req[2][1] = 15;
        run_round("t3", 0, 32'h0200, 5);

        set_all(0);
        run_round("t4", 0, 0, 3);

        set_all(15);
        run_round("t5", 1, -1, 0);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    unique case (r % 3)
                        0: m_req[i][j] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
                        1: m_req[i][j] = $urandom_range(0, 2);
                        default: m_req[i][j] = $urandom_range(0, 15);
                    endcase
                end
            end
            run_round($sformatf("rnd%0d", r), (r % 5 == 0), -1, 0);
        end

        set_all(15);
        @(negedge clk);
        pri_req_in = pack_req();
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6.busy", 32'(busy), 0);
        chk("t6.dec", 32'(decision), 0);
        chk("t6.cnt", 32'(match_count), 0);
        chk("t6.ready", 32'(decision_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int x = 0; x < N; x++) begin
            m_g[x] = 0;
            m_a[x] = 0;
        end
        sawr = 0;
        repeat (10) begin
            @(negedge clk);
            if (decision_ready) sawr++;
        end
        chk("t6.no_ready", sawr, 0);
        run_round("t6post", 0, 32'h8421, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
